fp_mult_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point multiplier with a valid/ready handshake, round-to-nearest-even and full special-value handling. It is the next-generation multiply unit feeding the systolic PE MAC path. It replaces a fixed fp32 4-stage multiplier that had no flow control, truncated its result and did not handle NaN/Inf. Format is set by parameters, so the same block serves fp32, bf16 and fp16 PEs.

---
 rtl/fp_mult_pipe.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_fp_mult_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: parametrised IEEE-754-style multiplier with RNE rounding, NaN/Inf/zero handling and flush-to-zero subnormals; flags port under FP_MULT_FLAGS_EN.
// Latency: 4 cycles from accept to out_valid, 1 result per cycle, order preserved.
// Backpressure: all stages freeze while out_valid && !out_ready; in_ready is simply !stall.
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result
`ifdef FP_MULT_FLAGS_EN
    ,
    output logic [3:0]               flags
`endif
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int XW   = EXP_W + 2;

    localparam logic signed [XW-1:0] BIAS_X    = XW'(BIAS);
    localparam logic signed [XW-1:0] EXP_MAX_X = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] ZERO_X    = '0;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        PK_NORM = 3'd0,
        PK_NAN  = 3'd1,
        PK_INF  = 3'd2,
        PK_ZERO = 3'd3,
        PK_OVF  = 3'd4,
        PK_UNF  = 3'd5
    } pack_kind_e;

    logic stall;

    // Stage 1 state: sign, exponents, significands and operand class summary
    logic                s1_vld_d,   s1_vld_q;
    logic                s1_sign_d,  s1_sign_q;
    logic [EXP_W-1:0]    s1_exp_a_d, s1_exp_a_q;
    logic [EXP_W-1:0]    s1_exp_b_d, s1_exp_b_q;
    logic [MAN_W:0]      s1_sig_a_d, s1_sig_a_q;
    logic [MAN_W:0]      s1_sig_b_d, s1_sig_b_q;
    logic                s1_nan_d,   s1_nan_q;
    logic                s1_inf_d,   s1_inf_q;
    logic                s1_zero_d,  s1_zero_q;

    // Stage 2 state: raw product and unbiased-sum exponent
    logic                s2_vld_d,   s2_vld_q;
    logic                s2_sign_d,  s2_sign_q;
    logic [PW-1:0]       s2_prod_d,  s2_prod_q;
    logic signed [XW-1:0] s2_exp_d,  s2_exp_q;
    logic                s2_nan_d,   s2_nan_q;
    logic                s2_inf_d,   s2_inf_q;
    logic                s2_zero_d,  s2_zero_q;

    // Stage 3 state: normalised, rounded mantissa and final exponent
    logic                s3_vld_d,   s3_vld_q;
    logic                s3_sign_d,  s3_sign_q;
    logic [MAN_W-1:0]    s3_man_d,   s3_man_q;
    logic signed [XW-1:0] s3_exp_d,  s3_exp_q;
    logic                s3_nan_d,   s3_nan_q;
    logic                s3_inf_d,   s3_inf_q;
    logic                s3_zero_d,  s3_zero_q;
`ifdef FP_MULT_FLAGS_EN
    logic                s3_inexact_d, s3_inexact_q;
    logic [3:0]          flags_d,    flags_q;
`endif

    // Stage 4 (output) state
    logic                out_vld_d,  out_vld_q;
    logic [W-1:0]        result_d,   result_q;

    // Decode helpers
    logic [EXP_W-1:0]    a_exp, b_exp;
    logic [MAN_W-1:0]    a_man, b_man;
    logic                a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    // Normalise/round helpers
    logic                nrm_msb;
    logic [2*MAN_W:0]    nrm;
    logic [MAN_W-1:0]    nrm_man;
    logic                rnd_guard, rnd_sticky, rnd_inc;
    logic [MAN_W:0]      rnd_sum;

    pack_kind_e          pk_kind;

    assign stall     = out_vld_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = out_vld_q;
    assign result    = result_q;
`ifdef FP_MULT_FLAGS_EN
    assign flags     = flags_q;
`endif

    // Stage 1: split fields and classify; subnormals (exp==0) count as zero
    always_comb begin
        a_exp  = a[W-2 -: EXP_W];
        b_exp  = b[W-2 -: EXP_W];
        a_man  = a[MAN_W-1:0];
        b_man  = b[MAN_W-1:0];
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);
        a_inf  = (&a_exp) && (a_man == '0);
        b_inf  = (&b_exp) && (b_man == '0);
        a_nan  = (&a_exp) && (a_man != '0);
        b_nan  = (&b_exp) && (b_man != '0);

        s1_vld_d   = stall ? s1_vld_q : (in_valid && in_ready);
        s1_sign_d  = s1_sign_q;
        s1_exp_a_d = s1_exp_a_q;
        s1_exp_b_d = s1_exp_b_q;
        s1_sig_a_d = s1_sig_a_q;
        s1_sig_b_d = s1_sig_b_q;
        s1_nan_d   = s1_nan_q;
        s1_inf_d   = s1_inf_q;
        s1_zero_d  = s1_zero_q;
        if (!stall && in_valid) begin
            s1_sign_d  = a[W-1] ^ b[W-1];
            s1_exp_a_d = a_exp;
            s1_exp_b_d = b_exp;
            s1_sig_a_d = {1'b1, a_man};
            s1_sig_b_d = {1'b1, b_man};
            s1_nan_d   = a_nan || b_nan;
            s1_inf_d   = a_inf || b_inf;
            s1_zero_d  = a_zero || b_zero;
        end
    end

    // Stage 2: full significand product and signed exponent sum (wide enough not to wrap)
    always_comb begin
        s2_vld_d  = stall ? s2_vld_q : s1_vld_q;
        s2_sign_d = s2_sign_q;
        s2_prod_d = s2_prod_q;
        s2_exp_d  = s2_exp_q;
        s2_nan_d  = s2_nan_q;
        s2_inf_d  = s2_inf_q;
        s2_zero_d = s2_zero_q;
        if (!stall && s1_vld_q) begin
            s2_sign_d = s1_sign_q;
            s2_prod_d = PW'(s1_sig_a_q) * PW'(s1_sig_b_q);
            s2_exp_d  = $signed({2'b00, s1_exp_a_q}) + $signed({2'b00, s1_exp_b_q}) - BIAS_X;
            s2_nan_d  = s1_nan_q;
            s2_inf_d  = s1_inf_q;
            s2_zero_d = s1_zero_q;
        end
    end

    // Stage 3: normalise to [1,2), round to nearest-even, fold rounding carry into exponent
    always_comb begin
        nrm_msb    = s2_prod_q[PW-1];
        nrm        = nrm_msb ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
        nrm_man    = nrm[2*MAN_W -: MAN_W];
        rnd_guard  = nrm[MAN_W];
        rnd_sticky = |nrm[MAN_W-1:0];
        rnd_inc    = rnd_guard && (rnd_sticky || nrm_man[0]);
        rnd_sum    = {1'b0, nrm_man} + {{MAN_W{1'b0}}, rnd_inc};

        s3_vld_d  = stall ? s3_vld_q : s2_vld_q;
        s3_sign_d = s3_sign_q;
        s3_man_d  = s3_man_q;
        s3_exp_d  = s3_exp_q;
        s3_nan_d  = s3_nan_q;
        s3_inf_d  = s3_inf_q;
        s3_zero_d = s3_zero_q;
`ifdef FP_MULT_FLAGS_EN
        s3_inexact_d = s3_inexact_q;
`endif
        if (!stall && s2_vld_q) begin
            s3_sign_d = s2_sign_q;
            // A carry out of the rounder leaves the low MAN_W bits at zero already
            s3_man_d  = rnd_sum[MAN_W-1:0];
            s3_exp_d  = s2_exp_q + $signed({{(XW-1){1'b0}}, nrm_msb})
                                 + $signed({{(XW-1){1'b0}}, rnd_sum[MAN_W]});
            s3_nan_d  = s2_nan_q;
            s3_inf_d  = s2_inf_q;
            s3_zero_d = s2_zero_q;
`ifdef FP_MULT_FLAGS_EN
            s3_inexact_d = rnd_guard || rnd_sticky;
`endif
        end
    end

    // Stage 4 classification: specials first, then exponent range
    always_comb begin
        pk_kind = PK_NORM;
        if (s3_nan_q || (s3_inf_q && s3_zero_q)) begin
            pk_kind = PK_NAN;
        end else if (s3_inf_q) begin
            pk_kind = PK_INF;
        end else if (s3_zero_q) begin
            pk_kind = PK_ZERO;
        end else if (s3_exp_q >= EXP_MAX_X) begin
            pk_kind = PK_OVF;
        end else if (s3_exp_q <= ZERO_X) begin
            pk_kind = PK_UNF;
        end
    end

    // Stage 4: pack the result word into the output register
    always_comb begin
        out_vld_d = stall ? out_vld_q : s3_vld_q;
        result_d  = result_q;
        if (!stall && s3_vld_q) begin
            case (pk_kind)
                PK_NAN:           result_d = QNAN;
                PK_INF, PK_OVF:   result_d = {s3_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                PK_ZERO, PK_UNF:  result_d = {s3_sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
                default:          result_d = {s3_sign_q, s3_exp_q[EXP_W-1:0], s3_man_q};
            endcase
        end
    end

`ifdef FP_MULT_FLAGS_EN
    // Stage 4 flags {invalid, overflow, underflow, inexact}, registered with the result
    always_comb begin
        flags_d = flags_q;
        if (!stall && s3_vld_q) begin
            case (pk_kind)
                PK_NAN:  flags_d = 4'b1000;
                PK_OVF:  flags_d = 4'b0101;
                PK_UNF:  flags_d = 4'b0011;
                PK_NORM: flags_d = {3'b000, s3_inexact_q};
                default: flags_d = 4'b0000;
            endcase
        end
    end
`endif

    // Pipeline registers; reset drops all in-flight work
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q   <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_a_q <= '0;
            s1_exp_b_q <= '0;
            s1_sig_a_q <= '0;
            s1_sig_b_q <= '0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_prod_q  <= '0;
            s2_exp_q   <= '0;
            s2_nan_q   <= 1'b0;
            s2_inf_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
            s3_vld_q   <= 1'b0;
            s3_sign_q  <= 1'b0;
            s3_man_q   <= '0;
            s3_exp_q   <= '0;
            s3_nan_q   <= 1'b0;
            s3_inf_q   <= 1'b0;
            s3_zero_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            result_q   <= '0;
`ifdef FP_MULT_FLAGS_EN
            s3_inexact_q <= 1'b0;
            flags_q      <= '0;
`endif
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_a_q <= s1_exp_a_d;
            s1_exp_b_q <= s1_exp_b_d;
            s1_sig_a_q <= s1_sig_a_d;
            s1_sig_b_q <= s1_sig_b_d;
            s1_nan_q   <= s1_nan_d;
            s1_inf_q   <= s1_inf_d;
            s1_zero_q  <= s1_zero_d;
            s2_vld_q   <= s2_vld_d;
            s2_sign_q  <= s2_sign_d;
            s2_prod_q  <= s2_prod_d;
            s2_exp_q   <= s2_exp_d;
            s2_nan_q   <= s2_nan_d;
            s2_inf_q   <= s2_inf_d;
            s2_zero_q  <= s2_zero_d;
            s3_vld_q   <= s3_vld_d;
            s3_sign_q  <= s3_sign_d;
            s3_man_q   <= s3_man_d;
            s3_exp_q   <= s3_exp_d;
            s3_nan_q   <= s3_nan_d;
            s3_inf_q   <= s3_inf_d;
            s3_zero_q  <= s3_zero_d;
            out_vld_q  <= out_vld_d;
            result_q   <= result_d;
`ifdef FP_MULT_FLAGS_EN
            s3_inexact_q <= s3_inexact_d;
            flags_q      <= flags_d;
`endif
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed checks of fp32 and bf16 instances of fp_mult_pipe.
// Latency: expects out_valid exactly 4 cycles after accept when unstalled.
// Backpressure: drives out_ready low for a window and checks in_ready/result hold.
module tb_fp_mult_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_result;
`ifdef FP_MULT_FLAGS_EN
    logic [3:0]  flags, h_flags;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] va [14];
    logic [31:0] vb [14];
    logic [31:0] vr [14];
    logic [3:0]  vf [14];

    int exp_q[$];
    int idx, got_n, n_extra, e;
    logic acc, saw_vld;

    always #5 clk = ~clk;

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) u_fp32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef FP_MULT_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    fp_mult_pipe #(.EXP_W(8), .MAN_W(7)) u_bf16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (h_in_valid),
        .in_ready  (h_in_ready),
        .a         (h_a),
        .b         (h_b),
        .out_valid (h_out_valid),
        .out_ready (h_out_ready),
        .result    (h_result)
`ifdef FP_MULT_FLAGS_EN
        ,
        .flags     (h_flags)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One fp32 operation through an otherwise idle pipe; checks latency, result and flags.
    task automatic op32(input int i, input string tag);
        int cyc;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = va[i];
        b = vb[i];
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_lat"}, 64'(cyc), 64'd4);
        check_eq(tag, 64'(result), 64'(vr[i]));
`ifdef FP_MULT_FLAGS_EN
        check_eq({tag, "_flg"}, 64'(flags), 64'(vf[i]));
`endif
    endtask

    // One bf16 operation through the bf16 instance.
    task automatic op16(input logic [15:0] xa, input logic [15:0] xb, input logic [15:0] xr,
                        input logic [3:0] xf, input string tag);
        int cyc;
        @(negedge clk);
        h_out_ready = 1'b1;
        h_in_valid  = 1'b1;
        h_a = xa;
        h_b = xb;
        @(negedge clk);
        h_in_valid = 1'b0;
        cyc = 1;
        while (!h_out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_lat"}, 64'(cyc), 64'd4);
        check_eq(tag, 64'(h_result), 64'(xr));
`ifdef FP_MULT_FLAGS_EN
        check_eq({tag, "_flg"}, 64'(h_flags), 64'(xf));
`else
        if (xf === 4'hx) $display("note: bf16 flag vector unknown");
`endif
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          a             b             result        flags {inv,ovf,unf,inx}
        va[0]  = 32'h3FC00000; vb[0]  = 32'h40000000; vr[0]  = 32'h40400000; vf[0]  = 4'b0000;
        va[1]  = 32'hC0000000; vb[1]  = 32'h40400000; vr[1]  = 32'hC0C00000; vf[1]  = 4'b0000;
        va[2]  = 32'h3F800001; vb[2]  = 32'h3F800001; vr[2]  = 32'h3F800002; vf[2]  = 4'b0001;
        va[3]  = 32'h3F800000; vb[3]  = 32'h3F800000; vr[3]  = 32'h3F800000; vf[3]  = 4'b0000;
        va[4]  = 32'h7F800000; vb[4]  = 32'h00000000; vr[4]  = 32'h7FC00000; vf[4]  = 4'b1000;
        va[5]  = 32'h7FC00001; vb[5]  = 32'h3F800000; vr[5]  = 32'h7FC00000; vf[5]  = 4'b1000;
        va[6]  = 32'hFF800000; vb[6]  = 32'h40000000; vr[6]  = 32'hFF800000; vf[6]  = 4'b0000;
        va[7]  = 32'h80000000; vb[7]  = 32'h3F800000; vr[7]  = 32'h80000000; vf[7]  = 4'b0000;
        va[8]  = 32'h7F000000; vb[8]  = 32'h7F000000; vr[8]  = 32'h7F800000; vf[8]  = 4'b0101;
        va[9]  = 32'h00800000; vb[9]  = 32'h00800000; vr[9]  = 32'h00000000; vf[9]  = 4'b0011;
        va[10] = 32'h00000001; vb[10] = 32'h3F800000; vr[10] = 32'h00000000; vf[10] = 4'b0000;
        // 1.5 * (1+u): exact tie on an odd lsb rounds up
        va[11] = 32'h3F800001; vb[11] = 32'h3FC00000; vr[11] = 32'h3FC00002; vf[11] = 4'b0001;
        // 1.5 * (1+3u): exact tie on an even lsb stays
        va[12] = 32'h3F800003; vb[12] = 32'h3FC00000; vr[12] = 32'h3FC00004; vf[12] = 4'b0001;
        // (1+u)*(2-2u) = 2-2u^2: all-ones mantissa rounds up and carries into exponent
        va[13] = 32'h3F800001; vb[13] = 32'h3FFFFFFE; vr[13] = 32'h40000000; vf[13] = 4'b0001;

        rst = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0;

        // Reset state
        #2;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_result",    64'(result),    64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        check_eq("rst_h_valid",   64'(h_out_valid), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Directed single operations
        for (int i = 0; i < 14; i++) op32(i, $sformatf("vec%0d", i));

        // Back-to-back stream of 8 with out_ready low for cycles 5..7
        idx = 0; got_n = 0; n_extra = 0;
        exp_q.delete();
        @(negedge clk);
        for (int k = 0; k < 24; k++) begin
            out_ready = !(k >= 5 && k <= 7);
            in_valid  = (idx < 8);
            if (idx < 8) begin
                a = va[idx];
                b = vb[idx];
            end
            #1;
            check_eq($sformatf("flow_rdy_k%0d", k), 64'(in_ready), (k >= 5 && k <= 7) ? 64'd0 : 64'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_extra++;
                end else begin
                    e = exp_q.pop_front();
                    check_eq($sformatf("flow_res%0d", got_n), 64'(result), 64'(vr[e]));
`ifdef FP_MULT_FLAGS_EN
                    check_eq($sformatf("flow_flg%0d", got_n), 64'(flags), 64'(vf[e]));
`endif
                    got_n++;
                end
            end
            if (out_valid && !out_ready && exp_q.size() > 0)
                check_eq($sformatf("flow_hold_k%0d", k), 64'(result), 64'(vr[exp_q[0]]));
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(idx);
                idx++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("flow_count",  64'(got_n),   64'd8);
        check_eq("flow_extra",  64'(n_extra), 64'd0);
        check_eq("flow_drained", 64'(out_valid), 64'd0);

        // Reset with op0 held at the output and two more in flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            a = va[k];
            b = vb[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_pre_vld", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_mid_vld",    64'(out_valid), 64'd0);
        check_eq("rst_mid_result", 64'(result),    64'd0);
        check_eq("rst_mid_rdy",    64'(in_ready),  64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        saw_vld = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) saw_vld = 1'b1;
        end
        check_eq("rst_no_stale", 64'(saw_vld), 64'd0);
        op32(3, "post_rst");

        // bf16 instance
        op16(16'h3FC0, 16'h4000, 16'h4040, 4'b0000, "bf16_mul");
        op16(16'h7F00, 16'h7F00, 16'h7F80, 4'b0101, "bf16_ovf");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
